// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID boundary with a 2-entry skid buffer between instruction memory and decode.
module if_id_stage #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [PC_W-1:0] PC_INC = {{(PC_W-1){1'b0}}, 1'b1},
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] im_dataout,
  input  logic               flush,
  input  logic               id_ready,
  output logic               fetch_stall,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus1
);
  logic [1:0]         r_cnt;
  logic               r_req;
  logic [PC_W-1:0]    r_req_pc, r_pc0, r_pc1;
  logic [INSTR_W-1:0] r_in0, r_in1;
  logic               w_valid, w_arrive, w_deq;
  logic [1:0]         w_cnt_nxt;

  assign w_valid     = !rst && r_cnt != 2'd0;
  assign w_arrive    = r_req && !flush;
  assign w_deq       = w_valid && id_ready;
  assign w_cnt_nxt   = r_cnt + {1'b0, w_arrive} - {1'b0, w_deq};
  // Stalling whenever the buffer will be full means no word can arrive into a full buffer.
  assign fetch_stall = !rst && !flush && w_cnt_nxt == 2'd2;
  assign id_valid    = w_valid;
  assign id_instr    = w_valid ? r_in0 : NOP_INSTR;
  assign id_pc       = rst ? '0 : r_pc0;
  assign id_pc_plus1 = id_pc + PC_INC;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 2'd0;
      r_req    <= 1'b0;
      r_req_pc <= '0;
      r_pc0    <= '0;
      r_pc1    <= '0;
      r_in0    <= '0;
      r_in1    <= '0;
    end else begin
      r_req    <= !flush && !fetch_stall;
      r_req_pc <= pc;
      r_cnt    <= flush ? 2'd0 : w_cnt_nxt;
      if (w_deq && r_cnt == 2'd2) {r_in0, r_pc0} <= {r_in1, r_pc1};
      // The arriving word always lands in the last occupied slot after this cycle.
      if (w_arrive && w_cnt_nxt == 2'd1) {r_in0, r_pc0} <= {im_dataout, r_req_pc};
      if (w_arrive && w_cnt_nxt == 2'd2) {r_in1, r_pc1} <= {im_dataout, r_req_pc};
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: scoreboard bench for if_id_stage with a one-cycle-latency memory model.
module tb_if_id_stage;
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] im_dataout;
  logic        flush = 1'b0;
  logic        id_ready = 1'b0;
  logic        fetch_stall, id_valid;
  logic [31:0] id_instr, id_pc, id_pc_plus1;
  logic [31:0] addr_q = '0;

  ent_t        q[$];
  ent_t        pend;
  logic        pend_v = 1'b0;
  logic        stall_m = 1'b0;
  logic        saw_stall = 1'b0;
  logic        saw_wrap = 1'b0;
  logic [31:0] cur_pc = 32'd5;
  int          n_tests = 0;
  int          n_fail = 0;

  if_id_stage dut (
    .clk(clk), .rst(rst), .pc(pc), .im_dataout(im_dataout), .flush(flush),
    .id_ready(id_ready), .fetch_stall(fetch_stall), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus1(id_pc_plus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) addr_q <= pc;
  assign im_dataout = 32'hA0 + addr_q;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic f, input logic rdy, input logic r);
    logic        ev, dq, arr;
    logic [31:0] p1;
    int          nxt;
    pc = cur_pc; flush = f; id_ready = rdy; rst = r;
    @(negedge clk);
    ev = !r && q.size() != 0;
    chk("valid", id_valid, ev);
    if (ev) begin
      p1 = q[0].pc + 32'd1;
      chk("instr", id_instr, q[0].ins);
      chk("pc", id_pc, q[0].pc);
      chk("pc_plus1", id_pc_plus1, p1);
      if (q[0].pc == 32'hFFFF_FFFF) begin
        chk("wrap", id_pc_plus1, 0);
        saw_wrap = 1'b1;
      end
    end else chk("nop", id_instr, 0);
    if (r) begin
      chk("rst_pc", id_pc, 0);
      chk("rst_pc_plus1", id_pc_plus1, 1);
    end
    dq  = ev && rdy;
    arr = pend_v && !f && !r;
    nxt = q.size() + int'(arr) - int'(dq);
    chk("occupancy_le_2", nxt <= 2, 1);
    stall_m = !r && !f && nxt == 2;
    chk("fetch_stall", fetch_stall, stall_m);
    if (fetch_stall) saw_stall = 1'b1;
    if (r) q.delete();
    else begin
      if (dq) void'(q.pop_front());
      if (f) q.delete();
      else if (arr) q.push_back(pend);
    end
    pend_v = !r && !f && !stall_m;
    pend   = {32'hA0 + pc, pc};
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input logic rdy);
    repeat (n) begin
      step(1'b0, rdy, 1'b0);
      if (!stall_m) cur_pc = cur_pc + 32'd1;
    end
  endtask

  initial begin
    cur_pc = 32'd5;
    repeat (2) step(1'b0, 1'b0, 1'b1);
    cur_pc = 32'd0;
    stream(8, 1'b1);
    saw_stall = 1'b0;
    stream(4, 1'b0);
    chk("stall_seen", saw_stall, 1);
    stream(6, 1'b1);
    stream(4, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    if (!stall_m) cur_pc = cur_pc + 32'd1;
    step(1'b1, 1'b1, 1'b0);
    cur_pc = 32'h40;
    stream(6, 1'b1);
    repeat (60) begin
      if ($urandom_range(0, 9) == 0) begin
        step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        cur_pc = 32'h100 + 32'($urandom_range(0, 255));
      end else stream(1, 1'($urandom_range(0, 1)));
    end
    stream(3, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    stream(4, 1'b1);
    cur_pc = 32'hFFFF_FFFE;
    stream(5, 1'b1);
    chk("wrap_seen", saw_wrap, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
